// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] wr_reg;
    logic             ld;
  } sb_entry_t;

  // Scoreboard index (0 = EX, 1 = MEM, 2 = WB) to forwarding select.
  function automatic logic [1:0] fwd_code(input int unsigned idx);
    case (idx)
      0:       fwd_code = FWD_EX;
      1:       fwd_code = FWD_MEM;
      2:       fwd_code = FWD_WB;
      default: fwd_code = FWD_RF;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_src_cmp.sv
// Compares one decode source register against every in-flight scoreboard entry.
module hazard_src_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned IDX_W     = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [REG_W-1:0]      src,
  input  logic                  live,
  output logic                  hit,
  output logic [IDX_W-1:0]      youngest_idx,
  output logic                  ld_hit
);

  logic [DEPTH-1:0] match;

  always_comb begin
    match        = '0;
    hit          = 1'b0;
    youngest_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = live && entries[i].v && (entries[i].wr_reg == src)
                 && !((WB_BYPASS != 0) && (i == DEPTH - 1));
    end
    // Lowest index is the youngest writer, so the first hit wins.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (match[i] && !hit) begin
        hit          = 1'b1;
        youngest_idx = IDX_W'(i);
      end
    end
    ld_hit = match[0] & entries[0].ld;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: shift scoreboard of in-flight writers, stall and forwarding selects.
// Optional HAZARD_FWD_EN: forwarding enabled, only load-use hazards stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_reads,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sb_entry_t [DEPTH-1:0] sb;
  logic                  rs_hit, rt_hit, rs_ld, rt_ld, hazard;
  logic [IDX_W-1:0]      rs_idx, rt_idx;

  hazard_src_cmp #(.DEPTH(DEPTH), .WB_BYPASS(WB_BYPASS), .IDX_W(IDX_W)) u_cmp_rs (
    .entries      (sb),
    .src          (id_rs),
    .live         (id_reads != 2'd0),
    .hit          (rs_hit),
    .youngest_idx (rs_idx),
    .ld_hit       (rs_ld)
  );

  hazard_src_cmp #(.DEPTH(DEPTH), .WB_BYPASS(WB_BYPASS), .IDX_W(IDX_W)) u_cmp_rt (
    .entries      (sb),
    .src          (id_rt),
    .live         (id_reads[1]),
    .hit          (rt_hit),
    .youngest_idx (rt_idx),
    .ld_hit       (rt_ld)
  );

`ifdef HAZARD_FWD_EN
  always_comb begin
    hazard     = rs_ld | rt_ld;
    fwd_rs_sel = (rs_hit && !stall) ? fwd_code(int unsigned'(rs_idx)) : FWD_RF;
    fwd_rt_sel = (rt_hit && !stall) ? fwd_code(int unsigned'(rt_idx)) : FWD_RF;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs_idx, rt_idx, rs_ld, rt_ld};

  always_comb begin
    hazard     = rs_hit | rt_hit;
    fwd_rs_sel = FWD_RF;
    fwd_rt_sel = FWD_RF;
  end
`endif

  assign stall = id_valid & ~flush & hazard;

  // The scoreboard advances every cycle; stalled or flushed decode pushes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb[0] <= '{v:      id_valid & ~flush & ~stall & id_wr_en,
                 wr_reg: id_wr_reg,
                 ld:     id_is_load};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (DEPTH=3, WB_BYPASS=1, CNT_W=4).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_reads;
  logic [2:0] id_rs, id_rt, id_wr_reg;
  logic       id_wr_en, id_is_load, flush;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [3:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_reads   (id_reads),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_wr_en   (id_wr_en),
    .id_wr_reg  (id_wr_reg),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic       valid;
    logic [1:0] reads;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       wr_en;
    logic [2:0] wr;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic [3:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] r, input logic [2:0] s,
                              input logic [2:0] t, input logic we, input logic [2:0] w,
                              input logic ld, input logic fl, input logic es,
                              input logic [3:0] ec);
    vec_t x;
    x.valid = v;  x.reads = r; x.rs = s;  x.rt = t;  x.wr_en = we;
    x.wr = w;     x.ld = ld;   x.fl = fl; x.e_stall = es; x.e_cnt = ec;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t x);
    id_valid = x.valid;  id_reads = x.reads; id_rs = x.rs; id_rt = x.rt;
    id_wr_en = x.wr_en;  id_wr_reg = x.wr;   id_is_load = x.ld; flush = x.fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl[21];
  vec_t ldr;
  int   found;

  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    // Inputs present a would-be hazard while in reset; outputs must stay low.
    drive(mk(1, 2, 3, 3, 1, 3, 0, 0, 0, 0));
    #2;
    chk("reset_stall", stall, 0);
    chk("reset_cnt", stall_cnt, 0);
    chk("reset_fwd_rs", fwd_rs_sel, 0);
    do_reset();

`ifndef HAZARD_FWD_EN
    //            v reads rs rt we wr ld fl stall cnt
    tbl[0]  = mk(1, 2, 1, 2, 1, 3, 0, 0, 0, 0);  // ADD r3
    tbl[1]  = mk(1, 2, 1, 3, 1, 5, 0, 0, 1, 0);  // SUB reads r3 (rt)
    tbl[2]  = mk(1, 2, 1, 3, 1, 5, 0, 0, 1, 1);
    tbl[3]  = mk(1, 2, 1, 3, 1, 5, 0, 0, 0, 2);  // r3 now in WB: bypassed
    tbl[4]  = mk(1, 0, 0, 0, 1, 4, 0, 0, 0, 2);  // writer r4
    tbl[5]  = mk(1, 0, 4, 4, 0, 0, 0, 0, 0, 2);  // no live sources
    tbl[6]  = mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 2);  // writer r5
    tbl[7]  = mk(1, 1, 0, 5, 0, 0, 0, 0, 0, 2);  // rt=r5 not live
    tbl[8]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 1, 2);  // rs=r5 live, r5 in MEM
    tbl[9]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 3);
    tbl[10] = mk(1, 0, 0, 0, 1, 6, 0, 0, 0, 3);  // writer r6
    tbl[11] = mk(1, 1, 6, 0, 1, 7, 0, 1, 0, 3);  // hazard but flushed
    tbl[12] = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 3);  // flushed r7 never entered
    tbl[13] = mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 3);  // writer r2
    tbl[14] = mk(0, 2, 2, 2, 0, 0, 0, 0, 0, 3);  // invalid decode never stalls
    tbl[15] = mk(1, 2, 2, 2, 1, 2, 0, 0, 1, 3);  // rs=rt=r2, writes r2
    tbl[16] = mk(1, 2, 2, 2, 1, 2, 0, 0, 0, 4);
    tbl[17] = mk(1, 3, 0, 2, 0, 0, 0, 0, 1, 4);  // reads=3 behaves as 2
    tbl[18] = mk(1, 3, 0, 2, 0, 0, 0, 0, 1, 5);
    tbl[19] = mk(1, 3, 0, 2, 0, 0, 0, 0, 0, 6);
    tbl[20] = mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 6);  // ADDI r1,r1 vs empty board

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("vec%0d_cnt", i), stall_cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d_fwd_rs", i), fwd_rs_sel, 0);
      chk($sformatf("vec%0d_fwd_rt", i), fwd_rt_sel, 0);
      tick();
    end
`else
    drive(mk(1, 1, 0, 0, 1, 2, 1, 0, 0, 0));  // LD r2
    #2; chk("fwd_ld_stall", stall, 0);
    tick();
    drive(mk(1, 1, 2, 0, 1, 3, 0, 0, 0, 0));  // ADDI r3 <- r2
    #2; chk("fwd_loaduse_stall", stall, 1);
    chk("fwd_loaduse_sel", fwd_rs_sel, 0);
    tick();
    #2; chk("fwd_after_stall", stall, 0);
    chk("fwd_mem_sel", fwd_rs_sel, 2);
    chk("fwd_cnt", stall_cnt, 1);
    tick();
    drive(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0));  // ADD r2 (non-load)
    #2; chk("fwd_alu_wr_stall", stall, 0);
    tick();
    drive(mk(1, 2, 2, 3, 0, 0, 0, 0, 0, 0));  // read r2 (EX) and r3 (MEM)
    #2; chk("fwd_alu_stall", stall, 0);
    chk("fwd_ex_sel_rs", fwd_rs_sel, 1);
    chk("fwd_mem_sel_rt", fwd_rt_sel, 2);
    tick();
`endif

    // Self-dependent load stream keeps re-creating the hazard: counter must saturate.
    do_reset();
    ldr = mk(1, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    drive(ldr);
    for (int i = 0; i < 40; i++) tick();
    #2;
    chk("sat_cnt", stall_cnt, 15);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (stall) found = 1;
      else begin
        tick();
        #2;
      end
    end
    chk("sat_find_stall", found, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_cnt", stall_cnt, 0);
    tick();
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("post_rst_cnt", stall_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
